otter_decode_queue: RTL and testbench

OTTER_DECODE_QUEUE -- requirements
Module: otter_decode_queue

---
 rtl/otter_decode_queue.sv | 218 +++++++++++++++++++++
 tb/tb_otter_decode_queue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_decode_queue.sv
// RV32I decode stage followed by a DEPTH-entry circular buffer of decoded instructions.
// Optional macro OTTER_DECODE_ILLEGAL_EN enables illegal-encoding detection.
module otter_decode_queue #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [31:0]                  IN_INSTR,
    input  logic [PC_W-1:0]              IN_PC,
    input  logic                         FLUSH,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [PC_W-1:0]              OUT_PC,
    output logic [4:0]                   OUT_RS1,
    output logic [4:0]                   OUT_RS2,
    output logic [4:0]                   OUT_RD,
    output logic [3:0]                   OUT_ALU_FUN,
    output logic                         OUT_ALU_SRCA,
    output logic [1:0]                   OUT_ALU_SRCB,
    output logic [1:0]                   OUT_RF_WR_SEL,
    output logic                         OUT_REG_WR,
    output logic                         OUT_MEM_WR,
    output logic                         OUT_MEM_RD,
    output logic                         OUT_BRANCH,
    output logic                         OUT_JUMP,
    output logic [2:0]                   OUT_BR_FUNC,
    output logic                         OUT_ILLEGAL,
    output logic [$clog2(DEPTH+1)-1:0]   OUT_COUNT
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_fun;
        logic            alu_srca;
        logic [1:0]      alu_srcb;
        logic [1:0]      rf_wr_sel;
        logic            reg_wr;
        logic            mem_wr;
        logic            mem_rd;
        logic            branch;
        logic            jump;
        logic [2:0]      br_func;
        logic            illegal;
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic       known_c;
    entry_t     dec_c;

    assign opcode = IN_INSTR[6:0];
    assign func3  = IN_INSTR[14:12];

    // Input-side decode; only the decoded entry is stored.
    always_comb begin
        dec_c           = '0;
        known_c         = 1'b1;
        dec_c.pc        = IN_PC;
        dec_c.rs1       = IN_INSTR[19:15];
        dec_c.rs2       = IN_INSTR[24:20];
        dec_c.rd        = IN_INSTR[11:7];
        dec_c.br_func   = func3;
        dec_c.rf_wr_sel = 2'd3;
        case (opcode)
            OPC_LUI: begin
                dec_c.alu_fun  = 4'b1001;
                dec_c.alu_srca = 1'b1;
                dec_c.reg_wr   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_c.alu_srca = 1'b1;
                dec_c.alu_srcb = 2'd3;
                dec_c.reg_wr   = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec_c.alu_srcb  = 2'd1;
                dec_c.rf_wr_sel = 2'd0;
                dec_c.reg_wr    = 1'b1;
                dec_c.jump      = 1'b1;
            end
            OPC_BRANCH: dec_c.branch = 1'b1;
            OPC_LOAD: begin
                dec_c.alu_srcb  = 2'd1;
                dec_c.rf_wr_sel = 2'd2;
                dec_c.reg_wr    = 1'b1;
                dec_c.mem_rd    = 1'b1;
            end
            OPC_STORE: begin
                dec_c.alu_srcb = 2'd2;
                dec_c.mem_wr   = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_c.alu_fun  = (func3 == 3'b101) ? {IN_INSTR[30], func3} : {1'b0, func3};
                dec_c.alu_srcb = 2'd1;
                dec_c.reg_wr   = 1'b1;
            end
            OPC_OP: begin
                dec_c.alu_fun = {IN_INSTR[30], func3};
                dec_c.reg_wr  = 1'b1;
            end
            OPC_SYSTEM: begin
                dec_c.alu_fun   = 4'b1001;
                dec_c.rf_wr_sel = 2'd1;
                dec_c.reg_wr    = 1'b1;
            end
            default: known_c = 1'b0;
        endcase
`ifdef OTTER_DECODE_ILLEGAL_EN
        dec_c.illegal = !known_c || (IN_INSTR[1:0] != 2'b11)
                     || ((opcode == OPC_OP) && (IN_INSTR[31:25] != 7'b0000000)
                                            && (IN_INSTR[31:25] != 7'b0100000))
                     || ((opcode == OPC_OP) && (IN_INSTR[31:25] == 7'b0100000)
                                            && (func3 != 3'b000) && (func3 != 3'b101))
                     || ((opcode == OPC_BRANCH) && ((func3 == 3'b010) || (func3 == 3'b011)));
        if (dec_c.illegal) begin
            dec_c.reg_wr = 1'b0;
            dec_c.mem_wr = 1'b0;
            dec_c.mem_rd = 1'b0;
            dec_c.branch = 1'b0;
            dec_c.jump   = 1'b0;
        end
`else
        dec_c.illegal = 1'b0;
`endif
    end

`ifndef OTTER_DECODE_ILLEGAL_EN
    logic unused_c;
    assign unused_c = ^{IN_INSTR[31], IN_INSTR[29:25], known_c};
`endif

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_c, pop_c;
    entry_t             head_c;

    assign IN_READY  = (count_q < CNT_W'(DEPTH));
    assign OUT_VALID = (count_q != '0);
    assign push_c    = IN_VALID && IN_READY;
    assign pop_c     = OUT_VALID && OUT_READY;

    // Flush wins over push/pop; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_c && !FLUSH && !RST) mem_q[wr_ptr_q] <= dec_c;
    end

    assign head_c        = OUT_VALID ? mem_q[rd_ptr_q] : '0;
    assign OUT_PC        = head_c.pc;
    assign OUT_RS1       = head_c.rs1;
    assign OUT_RS2       = head_c.rs2;
    assign OUT_RD        = head_c.rd;
    assign OUT_ALU_FUN   = head_c.alu_fun;
    assign OUT_ALU_SRCA  = head_c.alu_srca;
    assign OUT_ALU_SRCB  = head_c.alu_srcb;
    assign OUT_RF_WR_SEL = head_c.rf_wr_sel;
    assign OUT_REG_WR    = head_c.reg_wr;
    assign OUT_MEM_WR    = head_c.mem_wr;
    assign OUT_MEM_RD    = head_c.mem_rd;
    assign OUT_BRANCH    = head_c.branch;
    assign OUT_JUMP      = head_c.jump;
    assign OUT_BR_FUNC   = head_c.br_func;
    assign OUT_ILLEGAL   = head_c.illegal;
    assign OUT_COUNT     = count_q;

endmodule

// File: tb/tb_otter_decode_queue.sv
// Bench for otter_decode_queue: queue-based reference model checked every cycle, plus directed scenarios.
module tb_otter_decode_queue;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_fun;
        logic            srca;
        logic [1:0]      srcb;
        logic [1:0]      rf_sel;
        logic            reg_wr;
        logic            mem_wr;
        logic            mem_rd;
        logic            branch;
        logic            jump;
        logic [2:0]      br_func;
        logic            illegal;
    } dec_t;

    logic              CLK = 1'b0;
    logic              RST, IN_VALID, IN_READY, FLUSH, OUT_VALID, OUT_READY;
    logic [31:0]       IN_INSTR;
    logic [PC_W-1:0]   IN_PC, OUT_PC;
    logic [4:0]        OUT_RS1, OUT_RS2, OUT_RD;
    logic [3:0]        OUT_ALU_FUN;
    logic              OUT_ALU_SRCA;
    logic [1:0]        OUT_ALU_SRCB, OUT_RF_WR_SEL;
    logic              OUT_REG_WR, OUT_MEM_WR, OUT_MEM_RD, OUT_BRANCH, OUT_JUMP, OUT_ILLEGAL;
    logic [2:0]        OUT_BR_FUNC;
    logic [CNT_W-1:0]  OUT_COUNT;

    int n_checks = 0;
    int n_errors = 0;
    bit mdl_ok   = 0;
    dec_t mq[$];

`ifdef OTTER_DECODE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    otter_decode_queue #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_INSTR(IN_INSTR), .IN_PC(IN_PC), .FLUSH(FLUSH),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_PC(OUT_PC),
        .OUT_RS1(OUT_RS1), .OUT_RS2(OUT_RS2), .OUT_RD(OUT_RD),
        .OUT_ALU_FUN(OUT_ALU_FUN), .OUT_ALU_SRCA(OUT_ALU_SRCA), .OUT_ALU_SRCB(OUT_ALU_SRCB),
        .OUT_RF_WR_SEL(OUT_RF_WR_SEL), .OUT_REG_WR(OUT_REG_WR), .OUT_MEM_WR(OUT_MEM_WR),
        .OUT_MEM_RD(OUT_MEM_RD), .OUT_BRANCH(OUT_BRANCH), .OUT_JUMP(OUT_JUMP),
        .OUT_BR_FUNC(OUT_BR_FUNC), .OUT_ILLEGAL(OUT_ILLEGAL), .OUT_COUNT(OUT_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode, field by field from the opcode tables.
    function automatic dec_t model_decode(input logic [31:0] ins, input logic [PC_W-1:0] pc);
        dec_t d;
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        bit lui = (op == 7'b0110111), auipc = (op == 7'b0010111), jal = (op == 7'b1101111);
        bit jalr = (op == 7'b1100111), br = (op == 7'b1100011), ld = (op == 7'b0000011);
        bit st = (op == 7'b0100011), opi = (op == 7'b0010011), opr = (op == 7'b0110011);
        bit sys = (op == 7'b1110011);
        bit known = lui | auipc | jal | jalr | br | ld | st | opi | opr | sys;
        d = '0;
        d.pc = pc; d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.rd = ins[11:7]; d.br_func = f3;
        if (opr)             d.alu_fun = {ins[30], f3};
        else if (opi)        d.alu_fun = (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
        else if (lui || sys) d.alu_fun = 4'b1001;
        if (st)                            d.srcb = 2'd2;
        else if (ld || jal || jalr || opi) d.srcb = 2'd1;
        else if (auipc)                    d.srcb = 2'd3;
        d.srca = lui || auipc;
        if (jal || jalr) d.rf_sel = 2'd0;
        else if (sys)    d.rf_sel = 2'd1;
        else if (ld)     d.rf_sel = 2'd2;
        else             d.rf_sel = 2'd3;
        d.reg_wr = lui | auipc | jal | jalr | ld | opi | opr | sys;
        d.mem_wr = st;
        d.mem_rd = ld;
        d.branch = br;
        d.jump   = jal | jalr;
        if (ILL_EN) begin
            d.illegal = !known || ins[1:0] != 2'b11
                     || (opr && !(f7 == 7'h00 || f7 == 7'h20))
                     || (opr && f7 == 7'h20 && !(f3 == 3'd0 || f3 == 3'd5))
                     || (br && (f3 == 3'd2 || f3 == 3'd3));
            if (d.illegal) begin
                d.reg_wr = 0; d.mem_wr = 0; d.mem_rd = 0; d.branch = 0; d.jump = 0;
            end
        end
        return d;
    endfunction

    function automatic dec_t dut_head();
        dec_t a;
        a = '{pc: OUT_PC, rs1: OUT_RS1, rs2: OUT_RS2, rd: OUT_RD, alu_fun: OUT_ALU_FUN,
              srca: OUT_ALU_SRCA, srcb: OUT_ALU_SRCB, rf_sel: OUT_RF_WR_SEL,
              reg_wr: OUT_REG_WR, mem_wr: OUT_MEM_WR, mem_rd: OUT_MEM_RD,
              branch: OUT_BRANCH, jump: OUT_JUMP, br_func: OUT_BR_FUNC, illegal: OUT_ILLEGAL};
        return a;
    endfunction

    // Model update on the same edge the DUT sees.
    always @(posedge CLK) begin
        if (RST) begin
            mq.delete();
            mdl_ok = 1;
        end else if (mdl_ok) begin
            if (FLUSH) mq.delete();
            else begin
                bit push, pop;
                push = IN_VALID && (mq.size() < DEPTH);
                pop  = OUT_READY && (mq.size() > 0);
                if (pop)  void'(mq.pop_front());
                if (push) mq.push_back(model_decode(IN_INSTR, IN_PC));
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        if (mdl_ok) begin
            dec_t exp_h;
            exp_h = (mq.size() != 0) ? mq[0] : '0;
            chk("m_out_valid", 128'(OUT_VALID), 128'(mq.size() != 0));
            chk("m_count", 128'(OUT_COUNT), 128'(mq.size()));
            chk("m_in_ready", 128'(IN_READY), 128'(mq.size() < DEPTH));
            chk("m_head", 128'(dut_head()), 128'(exp_h));
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                         input logic rdy, input logic fl, input logic rst);
        IN_VALID = v; IN_INSTR = ins; IN_PC = pc; OUT_READY = rdy; FLUSH = fl; RST = rst;
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] SRAI = 32'h40415093;
    localparam logic [31:0] SW   = 32'h0020a023;
    localparam logic [31:0] ADDI2 = 32'h00100113;
    localparam logic [31:0] ADD  = 32'h00208133;
    localparam logic [31:0] JAL  = 32'h000000ef;

    logic [6:0] ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                             7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};

    initial begin
        dec_t pin;
        drive(0, 32'h0, '0, 0, 0, 1);
        step(); step();

        // Reset state
        chk("rst_valid", 128'(OUT_VALID), 128'(0));
        chk("rst_count", 128'(OUT_COUNT), 128'(0));
        chk("rst_ready", 128'(IN_READY), 128'(1));
        chk("rst_fields", 128'(dut_head()), 128'(0));

        // Model pins
        pin = model_decode(SRAI, 32'h0);
        chk("pin_srai_fun", 128'(pin.alu_fun), 128'(4'hD));
        pin = model_decode(SW, 32'h0);
        chk("pin_sw", 128'({pin.mem_wr, pin.srcb, pin.reg_wr}), 128'({1'b1, 2'd2, 1'b0}));

        // addi into empty queue
        drive(1, ADDI, 32'h100, 0, 0, 0); step();
        chk("addi_valid", 128'(OUT_VALID), 128'(1));
        chk("addi_fun", 128'(OUT_ALU_FUN), 128'(0));
        chk("addi_srcb", 128'(OUT_ALU_SRCB), 128'(1));
        chk("addi_rfsel", 128'(OUT_RF_WR_SEL), 128'(3));
        chk("addi_regwr", 128'(OUT_REG_WR), 128'(1));
        chk("addi_rd", 128'(OUT_RD), 128'(1));
        chk("addi_pc", 128'(OUT_PC), 128'(32'h100));
        drive(0, 32'h0, '0, 1, 0, 0); step();

        // srai then sw with stalled consumer
        drive(1, SRAI, 32'h104, 0, 0, 0); step();
        drive(1, SW, 32'h108, 0, 0, 0); step();
        chk("stall_count", 128'(OUT_COUNT), 128'(2));
        chk("stall_ready", 128'(IN_READY), 128'(0));
        chk("stall_fun", 128'(OUT_ALU_FUN), 128'(4'hD));
        drive(1, ADDI2, 32'h10c, 0, 0, 0); step();
        chk("stall_fun_hold", 128'(OUT_ALU_FUN), 128'(4'hD));
        chk("stall_pc_hold", 128'(OUT_PC), 128'(32'h104));
        drive(0, 32'h0, '0, 1, 0, 0); step();
        chk("sw_memwr", 128'(OUT_MEM_WR), 128'(1));
        chk("sw_srcb", 128'(OUT_ALU_SRCB), 128'(2));
        chk("sw_pc", 128'(OUT_PC), 128'(32'h108));

        // Full queue with simultaneous pop: push refused
        drive(1, ADDI2, 32'h200, 0, 0, 0); step();
        chk("full_count", 128'(OUT_COUNT), 128'(2));
        drive(1, ADD, 32'h300, 1, 0, 0);
        chk("full_ready", 128'(IN_READY), 128'(0));
        step();
        chk("full_pop_count", 128'(OUT_COUNT), 128'(1));
        chk("full_pop_pc", 128'(OUT_PC), 128'(32'h200));
        drive(1, ADD, 32'h300, 0, 0, 0); step();
        chk("refill_count", 128'(OUT_COUNT), 128'(2));

        // Flush with simultaneous jal
        drive(1, JAL, 32'h400, 0, 1, 0); step();
        chk("flush_count", 128'(OUT_COUNT), 128'(0));
        chk("flush_valid", 128'(OUT_VALID), 128'(0));
        drive(0, 32'h0, '0, 0, 0, 0); step();
        chk("flush_novalid", 128'(OUT_VALID), 128'(0));
        drive(1, ADDI, 32'h500, 0, 0, 0); step();
        drive(1, JAL, 32'h504, 0, 1, 0); step();
        chk("flush2_count", 128'(OUT_COUNT), 128'(0));
        drive(0, 32'h0, '0, 0, 0, 0); step();
        chk("flush2_nojal", 128'({OUT_VALID, OUT_JUMP}), 128'(0));

        // All-ones word
        drive(1, 32'hffffffff, 32'h600, 0, 0, 0); step();
        chk("ones_illegal", 128'(OUT_ILLEGAL), 128'(ILL_EN));
        chk("ones_enables", 128'({OUT_REG_WR, OUT_MEM_WR, OUT_MEM_RD, OUT_BRANCH, OUT_JUMP}), 128'(0));
        drive(0, 32'h0, '0, 1, 0, 0); step();

        // Reset with entries in flight
        drive(1, ADDI, 32'h700, 0, 0, 0); step();
        drive(1, SW, 32'h704, 0, 0, 0); step();
        drive(1, ADDI2, 32'h708, 0, 0, 1); step();
        chk("rst2_valid", 128'(OUT_VALID), 128'(0));
        chk("rst2_count", 128'(OUT_COUNT), 128'(0));
        chk("rst2_ready", 128'(IN_READY), 128'(1));
        chk("rst2_fields", 128'(dut_head()), 128'(0));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ins;
            int k;
            ins = $urandom;
            k = $urandom_range(0, 11);
            if (k < 10) begin
                ins[6:0] = ops[k];
                if (k == 8 && $urandom_range(0, 2) != 0)
                    ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            end
            drive($urandom_range(0, 3) != 0, ins, PC_W'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 199) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
